// File: rtl/sumador_pkg.sv
// Shared definitions for the bit-serial adder.
//   N_DEF    : default operand width
//   estado_t : FSM state encoding (REPOSO=0, SUMANDO=1, FIN=2)
//   ancho_cnt: bit-counter width for a given operand width
package sumador_pkg;

    localparam int N_DEF = 8;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        SUMANDO = 2'd1,
        FIN     = 2'd2
    } estado_t;

    // The counter has to represent 0..N, so it needs ceil(log2(N+1)) bits.
    function automatic int ancho_cnt(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sumador_serial_if.sv
// Bus between a requester and the serial adder.
//   INICIO, A, B, CIN : start request and operands (requester -> adder)
//   S, COUT           : registered result of the last completed operation
//   OCUPADO, LISTO    : busy flag and one-cycle completion pulse
// master = requester side, slave = adder side.
interface sumador_serial_if
    import sumador_pkg::*;
#(
    parameter int N = N_DEF
);
    logic         INICIO;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         CIN;
    logic [N-1:0] S;
    logic         COUT;
    logic         OCUPADO;
    logic         LISTO;

    modport master (
        output INICIO, A, B, CIN,
        input  S, COUT, OCUPADO, LISTO
    );

    modport slave (
        input  INICIO, A, B, CIN,
        output S, COUT, OCUPADO, LISTO
    );

endinterface

// File: rtl/sumador_completo.sv
// One-bit full adder, purely combinational.
//   A, B, CIN : addend bits and carry-in
//   S, COUT   : sum bit and carry-out
module sumador_completo (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic S,
    output logic COUT
);

    assign S    = A ^ B ^ CIN;
    assign COUT = (A & B) | (CIN & (A ^ B));

endmodule

// File: rtl/sumador_serial.sv
// Bit-serial adder: one bit pair per cycle, LSB first, through a single
// full-adder stage. A start is accepted only in REPOSO; the result is
// published on the edge that processes bit N-1, then FIN pulses LISTO.
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : slave side of sumador_serial_if (operands in, result/status out)
module sumador_serial
    import sumador_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    sumador_serial_if.slave  bus
);

    localparam int CW = ancho_cnt(N);

    estado_t       estado, estado_sig;
    logic [N-1:0]  a_sh, b_sh;   // captured operands, consumed from bit 0
    logic [N-1:0]  sr;           // sum bits enter at the MSB and walk down
    logic          carry;
    logic [CW-1:0] cnt;
    logic [N-1:0]  s_q;
    logic          cout_q;
    logic          s_bit, c_bit;
    logic          ultimo;

    assign ultimo = (cnt == CW'(N - 1));

    sumador_completo u_fa (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .CIN  (carry),
        .S    (s_bit),
        .COUT (c_bit)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) estado <= REPOSO;
        else        estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO:  if (bus.INICIO) estado_sig = SUMANDO;
            SUMANDO: if (ultimo)     estado_sig = FIN;
            FIN:                     estado_sig = REPOSO;
            default:                 estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sr     <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (bus.INICIO) begin
                        a_sh  <= bus.A;
                        b_sh  <= bus.B;
                        carry <= bus.CIN;
                        cnt   <= '0;
                    end
                end
                SUMANDO: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= c_bit;
                    sr    <= {s_bit, sr[N-1:1]};
                    cnt   <= cnt + CW'(1);
                    // Take the final bit straight from the adder so S is
                    // complete on this same edge.
                    if (ultimo) begin
                        s_q    <= {s_bit, sr[N-1:1]};
                        cout_q <= c_bit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.S       = s_q;
    assign bus.COUT    = cout_q;
    assign bus.OCUPADO = (estado == SUMANDO) || (estado == FIN);
    assign bus.LISTO   = (estado == FIN);

endmodule

// File: tb/tb_sumador_serial.sv
// Bench for sumador_serial at N=8 and N=2. Stimulus pushes the expected
// {COUT,S} and completion edge into a queue; a monitor pops on LISTO.
module tb_sumador_serial;
    import sumador_pkg::*;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    sumador_serial_if #(.N(8)) if8 ();
    sumador_serial_if #(.N(2)) if2 ();

    sumador_serial #(.N(8)) dut8 (.CLK(CLK), .RST_N(RST_N), .bus(if8));
    sumador_serial #(.N(2)) dut2 (.CLK(CLK), .RST_N(RST_N), .bus(if2));

    typedef struct {
        logic [63:0] v;
        int          ed;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // Monitor: every LISTO pulse must match the oldest outstanding result.
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N && if8.LISTO) begin
            if (q8.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL listo8_spurious: LISTO with no operation pending (cycle %0d)", cyc);
            end else begin
                e = q8.pop_front();
                check("sum8", 64'({if8.COUT, if8.S}), e.v);
                check("lat8", 64'(cyc), 64'(e.ed));
            end
        end
        if (RST_N && if2.LISTO) begin
            if (q2.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL listo2_spurious: LISTO with no operation pending (cycle %0d)", cyc);
            end else begin
                e = q2.pop_front();
                check("sum2", 64'({if2.COUT, if2.S}), e.v);
                check("lat2", 64'(cyc), 64'(e.ed));
            end
        end
    end

    // Called at a negedge with the adder idle; start is taken at the next edge.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
        exp_t e;
        if8.INICIO = 1'b1; if8.A = a; if8.B = b; if8.CIN = c;
        e.v  = 64'(a) + 64'(b) + 64'(c);
        e.ed = cyc + 1 + 8;
        q8.push_back(e);
        @(negedge CLK);
        if8.INICIO = 1'b0; if8.A = 8'($urandom); if8.B = 8'($urandom); if8.CIN = 1'($urandom);
    endtask

    task automatic start2(input logic [1:0] a, input logic [1:0] b, input logic c);
        exp_t e;
        if2.INICIO = 1'b1; if2.A = a; if2.B = b; if2.CIN = c;
        e.v  = 64'(a) + 64'(b) + 64'(c);
        e.ed = cyc + 1 + 2;
        q2.push_back(e);
        @(negedge CLK);
        if2.INICIO = 1'b0; if2.A = 2'($urandom); if2.B = 2'($urandom); if2.CIN = 1'($urandom);
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (if8.OCUPADO && n < 100) begin @(negedge CLK); n++; end
        if (n >= 100) begin n_vec++; n_err++; $display("FAIL idle8_timeout: still busy after %0d cycles", n); end
    endtask

    task automatic wait_idle2();
        int n = 0;
        while (if2.OCUPADO && n < 100) begin @(negedge CLK); n++; end
        if (n >= 100) begin n_vec++; n_err++; $display("FAIL idle2_timeout: still busy after %0d cycles", n); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int t1;
        if8.INICIO = 1'b0; if8.A = '0; if8.B = '0; if8.CIN = 1'b0;
        if2.INICIO = 1'b0; if2.A = '0; if2.B = '0; if2.CIN = 1'b0;
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_s",       64'(if8.S), 64'(0));
        check("rst_cout",    64'(if8.COUT), 64'(0));
        check("rst_listo",   64'(if8.LISTO), 64'(0));
        check("rst_ocupado", 64'(if8.OCUPADO), 64'(0));
        check("rst_ocupado2", 64'(if2.OCUPADO), 64'(0));
        RST_N = 1'b1;
        @(negedge CLK);
        check("no_start_after_rst", 64'(if8.OCUPADO), 64'(0));

        // 0+0: busy for N+1 cycles
        start8(8'h00, 8'h00, 1'b0);
        n = 0;
        while (if8.OCUPADO && n < 40) begin n++; @(negedge CLK); end
        check("busy_cycles", 64'(n), 64'(9));

        // Carry ripple through all bits
        start8(8'hFF, 8'h01, 1'b0); wait_idle8();
        start8(8'hA5, 8'h5A, 1'b1); wait_idle8();

        // INICIO with new A while busy must be ignored
        start8(8'h3C, 8'h0F, 1'b0);
        repeat (2) @(negedge CLK);
        if8.INICIO = 1'b1; if8.A = 8'h11;
        @(negedge CLK);
        if8.INICIO = 1'b0;
        wait_idle8();
        repeat (12) @(negedge CLK);
        check("s_after_ignore", 64'(if8.S), 64'(8'h4B));

        // S holds during SUMANDO, then reset mid-operation aborts
        start8(8'h12, 8'h34, 1'b0);
        repeat (2) @(negedge CLK);
        check("s_hold", 64'(if8.S), 64'(8'h4B));
        @(negedge CLK);
        @(posedge CLK);
        #2;
        q8.delete();
        RST_N = 1'b0;
        #1;
        check("abort_s",       64'(if8.S), 64'(0));
        check("abort_cout",    64'(if8.COUT), 64'(0));
        check("abort_listo",   64'(if8.LISTO), 64'(0));
        check("abort_ocupado", 64'(if8.OCUPADO), 64'(0));
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (20) @(negedge CLK);
        check("abort_s_stays", 64'(if8.S), 64'(0));
        check("abort_idle",    64'(if8.OCUPADO), 64'(0));

        // Back-to-back: second LISTO 10 cycles after the first
        start8(8'h01, 8'h02, 1'b0);
        n = 0;
        while (!if8.LISTO && n < 40) begin @(negedge CLK); n++; end
        t1 = cyc;
        @(negedge CLK);
        start8(8'h80, 8'h80, 1'b0);
        n = 0;
        while (!if8.LISTO && n < 40) begin @(negedge CLK); n++; end
        check("b2b_gap", 64'(cyc - t1), 64'(10));
        wait_idle8();

        // Random sweep on both widths in parallel
        fork
            begin
                repeat (200) begin
                    start8(8'($urandom), 8'($urandom), 1'($urandom));
                    wait_idle8();
                end
            end
            begin
                repeat (200) begin
                    start2(2'($urandom), 2'($urandom), 1'($urandom));
                    wait_idle2();
                end
            end
        join

        repeat (5) @(negedge CLK);
        check("q8_drained", 64'(q8.size()), 64'(0));
        check("q2_drained", 64'(q2.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sumador_serial.md
SUMADOR_SERIAL -- requirements
Module: sumador_serial

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits, legal range 2..32.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port INICIO  input  1  start request, sampled on the rising edge of CLK.
REQ-005 SHALL have port A  input  N  operand A, sampled only when a start is accepted.
REQ-006 SHALL have port B  input  N  operand B, sampled only when a start is accepted.
REQ-007 SHALL have port CIN  input  1  carry-in, sampled only when a start is accepted.
REQ-008 SHALL have port S  output  N  registered sum of the last completed operation.
REQ-009 SHALL have port COUT  output  1  registered carry-out of the last completed operation.
REQ-010 SHALL have port OCUPADO  output  1  high while in SUMANDO or FIN.
REQ-011 SHALL have port LISTO  output  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement the FSM states REPOSO, SUMANDO and FIN.
REQ-013 SHALL accept a start only when the FSM is in REPOSO and INICIO=1 at the edge; at that edge it captures A, B and CIN, clears the bit counter and moves to SUMANDO.
REQ-014 SHALL ignore INICIO in SUMANDO and FIN; S, COUT and the captured operands are unaffected.
REQ-015 SHALL, in SUMANDO, add one bit pair per cycle, LSB first, through one full-adder stage; the carry register starts at the captured CIN.
REQ-016 SHALL shift each sum bit into an internal N-bit shift register and increment the counter; the counter width is ceil(log2(N+1)).
REQ-017 SHALL, on the edge that processes bit N-1, load S from the completed shift register and COUT from the final carry, and move to FIN.
REQ-018 SHALL, in FIN, drive LISTO=1 for exactly one cycle and return to REPOSO on the next edge.
REQ-019 SHALL have a latency of N+1 edges: for a start accepted at edge k, LISTO is high from edge k+N to edge k+N+1, and S/COUT are valid from edge k+N.
REQ-020 SHALL keep S and COUT holding the previous result during SUMANDO; they change only at completion.
REQ-021 SHALL satisfy S + COUT*2^N = A + B + CIN for the captured operands, with no overflow or wrap other than COUT.
REQ-022 SHALL allow the earliest back-to-back start at the edge after FIN, i.e. one operation per N+2 cycles.
REQ-023 SHALL have LISTO and OCUPADO as pure decodes of the FSM state, with no combinational path from INICIO.

Reset
REQ-024 SHALL, on RST_N=0 and regardless of CLK, immediately force: state=REPOSO, S=0, COUT=0, LISTO=0, OCUPADO=0, counter=0, carry=0, shift register=0.
REQ-025 SHALL abort any operation in progress on a mid-operation reset, with no LISTO pulse and no partial result on S.
REQ-026 SHALL not accept a start on the first edge after RST_N deasserts unless INICIO=1 at that edge.

Structure
REQ-027 SHALL place the state encoding (2-bit REPOSO=0, SUMANDO=1, FIN=2) and the default N in the shared package sumador_pkg.
REQ-028 SHALL instantiate the one-bit stage as combinational sub-module sumador_completo (A, B, CIN -> S, COUT).

Verification (N=8)
REQ-029 SHALL cover: A=0x00, B=0x00, CIN=0, start -> S=0x00, COUT=0, LISTO at edge k+8, OCUPADO high for 9 cycles.
REQ-030 SHALL cover: A=0xFF, B=0x01, CIN=0 -> S=0x00, COUT=1; and A=0xA5, B=0x5A, CIN=1 -> S=0x00, COUT=1.
REQ-031 SHALL cover: A=0x3C, B=0x0F, CIN=0 started, then INICIO pulsed with A=0x11 at edge k+3 -> result S=0x4B, COUT=0, and only one LISTO pulse.
REQ-032 SHALL cover: RST_N low at edge k+4 of an operation -> all outputs 0 at once, no LISTO, and S stays 0x00 until a new start.
REQ-033 SHALL cover: two back-to-back starts (0x01+0x02, then 0x80+0x80) -> S=0x03/COUT=0, then S=0x00/COUT=1, with the second LISTO 10 cycles after the first.
REQ-034 SHALL cover: a random sweep of 200 operands against the reference model A+B+CIN at N=8 and N=2.
